// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL pulse generator and its receive-side counterpart.
package ttl_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int TIM_W_DEF = 16;
    localparam int DIV_DEF   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_FIN  = 2'd3
    } ttl_state_e;

endpackage

// File: rtl/ttl_phase_timer.sv
// Phase-length down-counter; shared by the high and low phases of each pulse.
module ttl_phase_timer #(
    parameter int TIM_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [TIM_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [TIM_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - TIM_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ttl_pulse_gen.sv
// Emits a burst of TTL pulses with programmable high/low times and a marker
// strobe on every DIV-th completed pulse.
module ttl_pulse_gen
    import ttl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TIM_W = TIM_W_DEF,
    parameter int DIV   = DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] pulse_count,
    input  logic [TIM_W-1:0] high_cycles,
    input  logic [TIM_W-1:0] low_cycles,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             op,
    output logic             marker,
    output logic [CNT_W-1:0] sent
);

    ttl_state_e       state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d, sent_q, sent_d;
    logic [TIM_W-1:0] hm1_q, hm1_d, lm1_q, lm1_d, tmr_val;
    logic [7:0]       mcnt_q, mcnt_d;
    logic             op_q, op_d, done_q, done_d, aborted_q, aborted_d, marker_q, marker_d;
    logic             tmr_load, tmr_exp;
    logic             accept, hi_end, lo_end, last_pulse, abort_take;

    // Timer is loaded with length-1; a zero length behaves as one cycle.
    function automatic logic [TIM_W-1:0] phase_m1(input logic [TIM_W-1:0] len);
        return (len == '0) ? '0 : len - TIM_W'(1);
    endfunction

    ttl_phase_timer #(.TIM_W(TIM_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .expired_o (tmr_exp)
    );

    assign last_pulse = (sent_q == n_q);
    assign accept     = (state_q == ST_IDLE) && start;
    assign hi_end     = (state_q == ST_HIGH) && tmr_exp && !abort;
    assign lo_end     = (state_q == ST_LOW) && tmr_exp;
    // Abort loses to a burst that is finishing normally in the same cycle.
    assign abort_take = abort && ((state_q == ST_HIGH) ||
                                  ((state_q == ST_LOW) && !(tmr_exp && last_pulse)));

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (pulse_count == '0) ? ST_FIN : ST_HIGH;
            ST_HIGH: begin
                if (abort)        state_d = ST_FIN;
                else if (tmr_exp) state_d = ST_LOW;
            end
            ST_LOW: begin
                if (tmr_exp && last_pulse) state_d = ST_FIN;
                else if (abort)            state_d = ST_FIN;
                else if (tmr_exp)          state_d = ST_HIGH;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        n_d       = n_q;
        hm1_d     = hm1_q;
        lm1_d     = lm1_q;
        sent_d    = sent_q;
        mcnt_d    = mcnt_q;
        aborted_d = aborted_q;
        marker_d  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = hm1_q;
        op_d      = (state_d == ST_HIGH);
        done_d    = (state_d == ST_FIN);
        if (accept) begin
            n_d       = pulse_count;
            hm1_d     = phase_m1(high_cycles);
            lm1_d     = phase_m1(low_cycles);
            sent_d    = '0;
            mcnt_d    = '0;
            aborted_d = 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = phase_m1(high_cycles);
        end
        if (hi_end) begin
            sent_d   = sent_q + CNT_W'(1);
            tmr_load = 1'b1;
            tmr_val  = lm1_q;
            if (mcnt_q == 8'(DIV - 1)) begin
                mcnt_d   = '0;
                marker_d = 1'b1;
            end else begin
                mcnt_d = mcnt_q + 8'd1;
            end
        end
        if (lo_end && !last_pulse && !abort) begin
            tmr_load = 1'b1;
            tmr_val  = hm1_q;
        end
        if (abort_take)
            aborted_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q       <= '0;
            hm1_q     <= '0;
            lm1_q     <= '0;
            sent_q    <= '0;
            mcnt_q    <= '0;
            op_q      <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            marker_q  <= 1'b0;
        end else begin
            n_q       <= n_d;
            hm1_q     <= hm1_d;
            lm1_q     <= lm1_d;
            sent_q    <= sent_d;
            mcnt_q    <= mcnt_d;
            op_q      <= op_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            marker_q  <= marker_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign busy    = (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign done    = done_q;
    assign aborted = aborted_q;
    assign op      = op_q;
    assign marker  = marker_q;
    assign sent    = sent_q;

endmodule

// File: tb/tb_ttl_pulse_gen.sv
// Scoreboard bench for ttl_pulse_gen: bursts are modelled as pulse-time arithmetic.
module tb_ttl_pulse_gen;

    localparam int CNT_W = 8;
    localparam int TIM_W = 16;
    localparam int DIV   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] pulse_count = '0;
    logic [TIM_W-1:0] high_cycles = '0;
    logic [TIM_W-1:0] low_cycles = '0;
    logic             ready, busy, done, aborted, op, marker;
    logic [CNT_W-1:0] sent;

    ttl_pulse_gen #(.CNT_W(CNT_W), .TIM_W(TIM_W), .DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pulse_count(pulse_count),
        .high_cycles(high_cycles),
        .low_cycles (low_cycles),
        .abort      (abort),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .op         (op),
        .marker     (marker),
        .sent       (sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int cyc;
        int sent;
        bit ab;
    } done_t;

    done_t done_q[$];
    int    mark_q[$];
    bit    op_hi[int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("op", {31'd0, op}, {31'd0, op_hi.exists(cyc) ? 1'b1 : 1'b0});
            while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
                chk("done_missing_at", 32'(cyc), 32'(done_q[0].cyc));
                void'(done_q.pop_front());
            end
            while (mark_q.size() > 0 && mark_q[0] < cyc) begin
                chk("marker_missing_at", 32'(cyc), 32'(mark_q[0]));
                void'(mark_q.pop_front());
            end
            if (done !== 1'b0) begin
                if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
                    chk("done_sent", {24'd0, sent}, 32'(done_q[0].sent));
                    chk("done_aborted", {31'd0, aborted}, {31'd0, done_q[0].ab});
                    void'(done_q.pop_front());
                end else begin
                    chk("done_unexpected", {31'd0, done}, 32'd0);
                end
            end
            if (marker !== 1'b0) begin
                if (mark_q.size() > 0 && mark_q[0] == cyc) begin
                    chk("marker", {31'd0, marker}, 32'd1);
                    void'(mark_q.pop_front());
                end else begin
                    chk("marker_unexpected", {31'd0, marker}, 32'd0);
                end
            end
        end
    end

    // ab_off/rst_off: cycle offset from the start cycle at which abort/reset is
    // pulsed (-1 for none). poke re-issues start while the burst is running.
    task automatic launch(input int n, input int h, input int l,
                          input int ab_off, input int rst_off, input bit poke);
        int t, he, le, p, stop, comp, end_off, exp_sent, c, rise, fall;
        bit ab_eff, fin;
        t      = cyc;
        he     = (h == 0) ? 1 : h;
        le     = (l == 0) ? 1 : l;
        p      = he + le;
        ab_eff = (n > 0) && (ab_off >= 0) && (ab_off != n * p);
        stop   = (rst_off >= 0) ? t + rst_off : (ab_eff ? t + ab_off : 32'h3fff_ffff);
        comp   = 0;
        for (int k = 0; k < n; k++) begin
            rise = t + 1 + k * p;
            fall = rise + he;
            for (int cc = rise; cc < fall && cc <= stop; cc++)
                op_hi[cc] = 1'b1;
            if (fall <= stop) begin
                comp++;
                if ((k + 1) % DIV == 0)
                    mark_q.push_back(fall);
            end
        end
        exp_sent = ab_eff ? comp : n;
        if (rst_off >= 0)
            end_off = rst_off + 1;
        else if (n == 0)
            end_off = 2;
        else if (ab_eff)
            end_off = ab_off + 2;
        else
            end_off = n * p + 2;
        if (rst_off < 0)
            done_q.push_back('{cyc: t + end_off - 1, sent: exp_sent, ab: ab_eff});

        fin = 1'b0;
        for (int i = 0; i < 5000 && !fin; i++) begin
            c = cyc - t;
            if (c == end_off) begin
                start = 1'b0;
                abort = 1'b0;
                reset = 1'b0;
                chk("end_ready", {31'd0, ready}, 32'd1);
                chk("end_busy", {31'd0, busy}, 32'd0);
                if (rst_off >= 0) begin
                    chk("rst_sent", {24'd0, sent}, 32'd0);
                    chk("rst_done", {31'd0, done}, 32'd0);
                end else begin
                    chk("hold_sent", {24'd0, sent}, 32'(exp_sent));
                    chk("hold_aborted", {31'd0, aborted}, {31'd0, ab_eff});
                end
                fin = 1'b1;
            end else begin
                start = (c == 0) || (poke && (c == 1 || c == ab_off));
                abort = (c == ab_off);
                reset = (c == rst_off);
                if (c == 0) begin
                    pulse_count = CNT_W'(n);
                    high_cycles = TIM_W'(h);
                    low_cycles  = TIM_W'(l);
                end else begin
                    pulse_count = CNT_W'($urandom);
                    high_cycles = TIM_W'($urandom_range(0, 7));
                    low_cycles  = TIM_W'($urandom_range(0, 7));
                end
                @(negedge clk);
            end
        end
        if (!fin)
            chk("burst_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n, h, l, ab;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_op", {31'd0, op}, 32'd0);
        chk("rst_sent0", {24'd0, sent}, 32'd0);
        chk("rst_done0", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_aborted", {31'd0, aborted}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        launch(0, 1, 1, -1, -1, 1'b0);
        launch(10, 3, 2, -1, -1, 1'b0);
        launch(4, 0, 0, -1, -1, 1'b0);
        launch(8, 4, 4, 18, -1, 1'b1);
        launch(20, 2, 2, -1, 25, 1'b0);
        launch(5, 1, 1, -1, -1, 1'b0);
        launch(3, 2, 2, 12, -1, 1'b0);
        launch(6, 1, 2, 3, -1, 1'b0);

        for (int r = 0; r < 16; r++) begin
            n  = $urandom_range(0, 12);
            h  = $urandom_range(0, 3);
            l  = $urandom_range(0, 3);
            ab = -1;
            if (n > 0 && $urandom_range(0, 2) == 0)
                ab = $urandom_range(1, n * ((h == 0 ? 1 : h) + (l == 0 ? 1 : l)));
            launch(n, h, l, ab, -1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);
        chk("marker_queue_empty", 32'(mark_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", nerr);
        $fatal(1);
    end

endmodule
